// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem requests,
// queues returned words and presents {inst, inst_pc} to the core over valid/ready.
module ifu_fetch #(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h8000_0000),
   parameter int               QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [31:0]       imem_resp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [XLEN-1:0]   inst_pc
);

   // state  | meaning
   // S_REQ  | may issue a request (when the queue has a free slot)
   // S_WAIT | one request outstanding, its response will be queued
   // S_DROP | one request outstanding, its response is stale and discarded
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   localparam int            PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int            CW    = PW + 1;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   state_t            state_q,     state_d;
   logic [XLEN-1:0]   pc_q,        pc_d;
   logic [XLEN-1:0]   req_pc_q,    req_pc_d;
   logic              req_valid_q, req_valid_d;
   logic [31:0]       q_inst_q [QDEPTH];
   logic [31:0]       q_inst_d [QDEPTH];
   logic [XLEN-1:0]   q_pc_q   [QDEPTH];
   logic [XLEN-1:0]   q_pc_d   [QDEPTH];
   logic [PW-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [CW-1:0]     count_q,     count_d;

   logic              req_hs;
   logic              push;
   logic              pop;
   logic              unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign req_hs = req_valid_q && imem_req_ready && (state_q == S_REQ);
   assign pop    = (count_q != '0) && inst_ready;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;

      case (state_q)
         S_REQ: begin
            if (req_hs) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + XLEN'(4);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               push    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect outranks everything; a request accepted this cycle becomes stale
      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         push = 1'b0;
         case (state_q)
            S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
            S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
            S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end
   end

   always_comb begin
      q_inst_d = q_inst_q;
      q_pc_d   = q_pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (push) begin
         q_inst_d[wr_ptr_q] = imem_resp_data;
         q_pc_d[wr_ptr_q]   = req_pc_q;
         wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // The head popped in a redirect cycle is delivered; everything behind it is flushed
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Credit check on the next-cycle count keeps a slot free for the outstanding response
   always_comb begin
      req_valid_d = (state_d == S_REQ) && (count_d < QFULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         req_valid_q <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_inst_q[i] <= '0;
            q_pc_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         q_inst_q    <= q_inst_d;
         q_pc_q      <= q_pc_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (count_q != '0);
   assign inst           = inst_valid ? q_inst_q[rd_ptr_q] : 32'h0;
   assign inst_pc        = inst_valid ? q_pc_q[rd_ptr_q]   : '0;

endmodule
